// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-aware AXI-stream arbiter.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        TERM
    } state_t;

    // Index width for n ports, never narrower than one bit.
    function automatic int gw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin picker: first requesting port after last_grant, with wrap.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int GW     = gw_of(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [GW-1:0]     last_grant,
    output logic [GW-1:0]     pick,
    output logic              any_req
);

    logic          found;
    logic [GW-1:0] sel;

    // Scan ports last_grant+1 .. last_grant+NUM_IN; the first hit wins.
    always_comb begin
        pick    = '0;
        found   = 1'b0;
        sel     = '0;
        any_req = |req;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            sel = GW'((32'(last_grant) + k) % NUM_IN);
            if (!found && req[sel]) begin
                pick  = sel;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-aware round-robin AXI-stream arbiter with per-source frame flush.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int DWIDTH = 32,
    parameter  int UWIDTH = 1,
    localparam int GW     = gw_of(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_IN-1:0]        flush,
    input  logic [NUM_IN-1:0]        s_valid,
    input  logic [NUM_IN-1:0]        s_last,
    input  logic [NUM_IN*DWIDTH-1:0] s_data,
    input  logic [NUM_IN*UWIDTH-1:0] s_user,
    output logic [NUM_IN-1:0]        s_ready,
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic                     m_last,
    output logic [DWIDTH-1:0]        m_data,
    output logic [UWIDTH-1:0]        m_user,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);

    state_t        state;
    logic [GW-1:0] last_grant;
    logic          beat_seen;
    logic [GW-1:0] pick;
    logic          any_req;
    logic          hs;

    axis_rr_pick #(
        .NUM_IN (NUM_IN),
        .GW     (GW)
    ) u_pick (
        .req        (s_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_req    (any_req)
    );

    // Output mux: granted port passes straight through in PASS; TERM emits a zero last beat.
    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        m_user  = '0;
        s_ready = '0;
        case (state)
            PASS: begin
                m_valid           = s_valid[grant_id];
                m_last            = s_last[grant_id];
                m_data            = s_data[32'(grant_id)*DWIDTH +: DWIDTH];
                m_user            = s_user[32'(grant_id)*UWIDTH +: UWIDTH];
                s_ready[grant_id] = m_ready;
            end
            TERM: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign hs = m_valid && m_ready;

    // Arbitration FSM; a real last beat outranks flush, and flush before any beat just releases the grant.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_IN - 1);
            beat_seen  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= pick;
                        beat_seen <= 1'b0;
                        state     <= PASS;
                        busy      <= 1'b1;
                    end
                end
                PASS: begin
                    if (hs)
                        beat_seen <= 1'b1;
                    if (hs && m_last) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                    end else if (flush[grant_id] && (beat_seen || hs)) begin
                        state <= TERM;
                    end else if (flush[grant_id]) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                    end
                end
                TERM: begin
                    if (m_ready) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed self-checking bench for axis_frame_arbiter (4 ports, 32-bit data).
module tb_axis_frame_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   flush;
    logic [3:0]   s_valid;
    logic [3:0]   s_last;
    logic [127:0] s_data;
    logic [3:0]   s_user;
    logic [3:0]   s_ready;
    logic         m_ready;
    logic         m_valid;
    logic         m_last;
    logic [31:0]  m_data;
    logic [0:0]   m_user;
    logic [1:0]   grant_id;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    axis_frame_arbiter #(
        .NUM_IN (4),
        .DWIDTH (32),
        .UWIDTH (1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_data   (s_data),
        .s_user   (s_user),
        .s_ready  (s_ready),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_data   (m_data),
        .m_user   (m_user),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int p, input logic [31:0] d);
        s_data[p*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned beat;
        int unsigned cyc;
        logic        mr;

        rstn    = 1'b0;
        flush   = '0;
        s_valid = '0;
        s_last  = '0;
        s_data  = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
        s_user  = '0;
        m_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        rstn = 1'b1;
        tick();

        // Basic grant from ports 1,2 (port 0 has first priority but is idle)
        s_valid = 4'b0110;
        #1;
        chk("t1_idle_m_valid", m_valid, 0);
        chk("t1_idle_s_ready", s_ready, 0);
        tick();
        chk("t1_grant", grant_id, 1);
        chk("t1_busy", busy, 1);
        m_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_data(1, 32'hA1 + 32'(b));
            s_last[1] = (b == 2);
            #1;
            chk("t1_m_valid", m_valid, 1);
            chk("t1_m_data", m_data, 32'hA1 + 32'(b));
            chk("t1_m_last", m_last, (b == 2) ? 1 : 0);
            chk("t1_s_ready", s_ready, 4'b0010);
            tick();
        end
        s_last = '0;
        chk("t1_gap_busy", busy, 0);
        chk("t1_gap_m_valid", m_valid, 0);
        tick();
        chk("t1_next_grant", grant_id, 2);
        set_data(2, 32'hC1);
        s_last[2] = 1'b1;
        #1;
        chk("t1_p2_data", m_data, 32'hC1);
        chk("t1_p2_s_ready", s_ready, 4'b0100);
        tick();
        s_valid = '0;
        s_last  = '0;
        tick();

        // Round robin with all ports valid, 2-beat frames
        rstn = 1'b0;
        tick();
        rstn    = 1'b1;
        s_valid = 4'b1111;
        m_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int g;
            g = f % 4;
            tick();
            chk("t2_grant", grant_id, 64'(g));
            for (int b = 0; b < 2; b++) begin
                set_data(g, 32'hB0000000 | 32'(f << 4) | 32'(b));
                s_last[g] = (b == 1);
                #1;
                chk("t2_m_data", m_data, 32'hB0000000 | 32'(f << 4) | 32'(b));
                chk("t2_m_last", m_last, (b == 1) ? 1 : 0);
                chk("t2_s_ready", s_ready, 4'b0001 << g);
                tick();
            end
            s_last[g] = 1'b0;
            chk("t2_gap_busy", busy, 0);
            chk("t2_gap_m_valid", m_valid, 0);
        end
        s_valid = '0;
        tick();

        // Flush after two beats on port 2 -> terminator held under backpressure
        s_valid = 4'b0100;
        tick();
        chk("t3_grant", grant_id, 2);
        for (int b = 0; b < 2; b++) begin
            set_data(2, 32'hD1 + 32'(b));
            #1;
            chk("t3_m_data", m_data, 32'hD1 + 32'(b));
            tick();
        end
        flush[2] = 1'b1;
        m_ready  = 1'b0;
        set_data(2, 32'hD3);
        #1;
        chk("t3_pre_m_valid", m_valid, 1);
        tick();
        flush   = '0;
        s_valid = '0;
        for (int c = 0; c < 3; c++) begin
            chk("t3_term_valid", m_valid, 1);
            chk("t3_term_last", m_last, 1);
            chk("t3_term_data", m_data, 0);
            chk("t3_term_s_ready", s_ready, 0);
            chk("t3_term_busy", busy, 1);
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("t3_term_hs_valid", m_valid, 1);
        chk("t3_term_hs_last", m_last, 1);
        tick();
        chk("t3_after_busy", busy, 0);
        chk("t3_after_m_valid", m_valid, 0);

        // Flush together with the real last handshake -> no terminator
        s_valid = 4'b1000;
        tick();
        chk("t4_grant", grant_id, 3);
        set_data(3, 32'hF1);
        s_last[3] = 1'b1;
        flush[3]  = 1'b1;
        #1;
        chk("t4_m_last", m_last, 1);
        chk("t4_m_data", m_data, 32'hF1);
        tick();
        flush   = '0;
        s_valid = '0;
        s_last  = '0;
        #1;
        chk("t4_no_term_busy", busy, 0);
        chk("t4_no_term_valid", m_valid, 0);
        tick();

        // Flush in the first PASS cycle without handshake -> release, rotate past port 0
        s_valid = 4'b0001;
        tick();
        chk("t5_grant", grant_id, 0);
        m_ready  = 1'b0;
        flush[0] = 1'b1;
        tick();
        flush   = '0;
        s_valid = 4'b0011;
        #1;
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_valid", m_valid, 0);
        tick();
        chk("t5_rotated_grant", grant_id, 1);
        flush[1] = 1'b1;
        tick();
        flush   = '0;
        s_valid = '0;
        chk("t5b_idle_busy", busy, 0);
        tick();

        // 16-beat frame under random backpressure on port 0
        s_valid = 4'b0001;
        tick();
        chk("t6_grant", grant_id, 0);
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 200) begin
            mr      = 1'($urandom_range(0, 1));
            m_ready = mr;
            set_data(0, 32'hE00 + beat);
            s_last[0] = (beat == 15);
            #1;
            chk("t6_s_ready", s_ready, {3'b000, mr});
            chk("t6_m_data", m_data, 32'hE00 + beat);
            tick();
            if (mr)
                beat++;
            cyc++;
        end
        chk("t6_frame_complete", beat, 16);
        s_valid = '0;
        s_last  = '0;
        #1;
        chk("t6_after_busy", busy, 0);
        tick();

        // Reset in the middle of a frame on port 2
        s_valid = 4'b0100;
        m_ready = 1'b1;
        tick();
        chk("t7_grant", grant_id, 2);
        set_data(2, 32'h77);
        tick();
        rstn = 1'b0;
        tick();
        chk("t7_rst_m_valid", m_valid, 0);
        chk("t7_rst_grant", grant_id, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_s_ready", s_ready, 0);
        rstn    = 1'b1;
        s_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_arbiter.md
# axis_frame_arbiter

Frame-aware round-robin arbiter that shares one AXI-stream master port between NUM_IN AXI-stream sources. A grant is held for a complete frame (through the beat with s_last), so frames are never interleaved. A per-source flush request aborts the granted source's frame cleanly by injecting a terminating last beat downstream. It sits ahead of any shared framed consumer, such as a DMA writer or packetizer, that must only ever see whole frames.

## Interface
- NUM_IN, 4, number of source ports (≥2)
- DWIDTH, 32, data width per port
- UWIDTH, 1, user sideband width per port
- GW, derived, $clog2(NUM_IN); grant index width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  NUM_IN  per-source abort request, level-sensitive
- s_valid  in  NUM_IN  source valid, bit i = port i
- s_last  in  NUM_IN  source last
- s_data  in  NUM_IN*DWIDTH  port i at [i*DWIDTH +: DWIDTH]
- s_user  in  NUM_IN*UWIDTH  port i at [i*UWIDTH +: UWIDTH]
- s_ready  out  NUM_IN  source ready
- m_ready  in  1  sink ready
- m_valid  out  1  sink valid
- m_last  out  1  sink last
- m_data  out  DWIDTH  sink data
- m_user  out  UWIDTH  sink user
- grant_id  out  GW  index of the granted port (registered)
- busy  out  1  high in PASS or TERM

## Operation
- States: IDLE, PASS, TERM. Registers: state, grant_id, last_grant, beat_seen.
- IDLE:
  - m_valid=0 and all s_ready=0.
  - If any s_valid is high, pick the first set bit searching from (last_grant+1) mod NUM_IN upward with wrap.
  - Register the pick into grant_id, clear beat_seen, and go to PASS.
- PASS (g = grant_id):
  - m_valid=s_valid[g], m_last=s_last[g], m_data/m_user = port g.
  - s_ready[g]=m_ready; all other s_ready=0.
  - Each m_valid&&m_ready sets beat_seen.
- PASS exits, in priority order:
  1. Handshake with m_last=1: go to IDLE and set last_grant<=g. This takes priority over flush[g] in the same cycle, so no terminator is sent.
  2. flush[g]=1 with beat_seen=1, or with a non-last handshake in the same cycle: go to TERM.
  3. flush[g]=1 with no beat yet transferred and no handshake this cycle: go to IDLE, set last_grant<=g, and send no terminator.
- TERM:
  - m_valid=1, m_last=1, m_data=0, m_user=0, all s_ready=0.
  - When m_ready=1: go to IDLE and set last_grant<=g.
  - TERM ignores flush.
- flush on non-granted ports is ignored. The source owns discarding its own data.
- Reset: state=IDLE, grant_id=0, last_grant=NUM_IN-1 (port 0 has first priority), beat_seen=0.
  - Outputs during and after reset: m_valid=0, m_last=0, s_ready=0, busy=0.

## Timing
- Arbitration latency is 1 cycle: s_valid high in IDLE at cycle N gives PASS at N+1, and the first beat can transfer at N+1.
- Inter-frame bubble is exactly 1 IDLE cycle after the last handshake or the terminator handshake.
- In PASS, ready/valid are combinational through the mux. There is no added register stage and throughput is 1 beat/cycle.
- The terminator is presented the cycle after flush is sampled. It is held stable until m_ready (AXIS rule: valid never drops without a handshake).
- Arbitration samples s_valid only in IDLE. Requests that appear during PASS wait for the next IDLE.
- Reset mid-frame drops the frame immediately with no terminator. The downstream block is reset together with this one.

## Structure
- Package axis_arb_pkg holds:
  - state enum {IDLE, PASS, TERM}
  - the GW derivation function (clog2 with a minimum of 1)
- One sub-module, axis_rr_pick:
  - purely combinational
  - inputs: req[NUM_IN] and last_grant
  - outputs: pick index and any_req
- The FSM, mux, and terminator logic live in axis_frame_arbiter.

## Test plan
- Reset, then s_valid=4'b0110 → grant_id=1 one cycle later; a 3-beat frame 0xA1..0xA3 passes intact; next grant_id=2.
- All 4 ports continuously valid with 2-beat frames → grant order 0,1,2,3,0; no interleaving; a 1-cycle gap between frames.
- Port 2 granted, 2 beats sent, flush[2]=1 → next cycle m_valid=1, m_last=1, m_data=0; with m_ready held low 3 cycles the terminator is held; on handshake go to IDLE.
- flush[g] in the same cycle as the s_last handshake → no terminator; IDLE next cycle.
- flush[g] in the first PASS cycle with m_ready=0 → IDLE next cycle, no m_valid seen, last_grant=g.
- Backpressure: m_ready toggled randomly during a 16-beat frame → s_ready[g] mirrors m_ready; data order preserved; rstn low mid-frame → m_valid=0 the next cycle, grant_id=0.
